// File: rtl/fan_control_pkg.sv
// Shared definitions for the multi-channel fan controller: register map, mode encoding and
// auto-control state type.
package fan_control_pkg;

  localparam logic [2:0] RegDutyTarget = 3'd0;
  localparam logic [2:0] RegDutyActual = 3'd1;
  localparam logic [2:0] RegMode       = 3'd2;
  localparam logic [2:0] RegThrLow     = 3'd3;
  localparam logic [2:0] RegThrHigh    = 3'd4;
  localparam logic [2:0] RegRampStep   = 3'd5;
  localparam logic [2:0] RegEnable     = 3'd6;
  localparam logic [2:0] RegAutoState  = 3'd7;

  localparam logic ModeManual = 1'b0;
  localparam logic ModeAuto   = 1'b1;

  typedef enum logic {AutoLow = 1'b0, AutoHigh = 1'b1} auto_state_e;

endpackage

// File: rtl/fan_pwm_channel.sv
// One fan channel: register file, period-boundary duty ramp, optional auto FSM and PWM compare.
// Auto mode is built only when FAN_CONTROL_AUTO_MODE_EN is defined.
module fan_pwm_channel
  import fan_control_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en_i,
  input  logic [2:0]          reg_sel_i,
  input  logic [31:0]         wdata_i,
  input  logic                boundary_i,
  input  logic [PWM_BITS-1:0] counter_i,
  input  logic [31:0]         current_i,
  output logic [31:0]         rdata_o,
  output logic                pwm_o
);

  localparam logic [PWM_BITS-1:0] DutyMax = '1;

  logic [PWM_BITS-1:0] duty_target_q, duty_actual_q, duty_actual_d, ramp_step_q;
  logic [PWM_BITS-1:0] target_eff, down_gap;
  logic [PWM_BITS:0]   up_sum;
  logic                enable_q, pwm_q;

`ifdef FAN_CONTROL_AUTO_MODE_EN
  logic        mode_q;
  logic [31:0] thr_low_q, thr_high_q;
  auto_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (boundary_i && mode_q == ModeAuto) begin
      unique case (state_q)
        AutoLow:  if (current_i > thr_high_q) state_d = AutoHigh;
        AutoHigh: if (current_i < thr_low_q)  state_d = AutoLow;
        default:  state_d = AutoLow;
      endcase
    end
    // Leaving auto or disabling the channel always drops back to LOW.
    if (wr_en_i && !wdata_i[0] && (reg_sel_i == RegMode || reg_sel_i == RegEnable)) begin
      state_d = AutoLow;
    end
  end

  always_comb begin
    target_eff = duty_target_q;
    if (mode_q == ModeAuto && state_q == AutoHigh) target_eff = DutyMax;
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{current_i, wdata_i[31:PWM_BITS]};
  assign target_eff    = duty_target_q;
`endif

  always_comb begin
    up_sum        = {1'b0, duty_actual_q} + {1'b0, ramp_step_q};
    down_gap      = duty_actual_q - target_eff;
    duty_actual_d = duty_actual_q;
    if (ramp_step_q == '0) begin
      duty_actual_d = target_eff;
    end else if (duty_actual_q < target_eff) begin
      duty_actual_d = (up_sum >= {1'b0, target_eff}) ? target_eff : up_sum[PWM_BITS-1:0];
    end else if (duty_actual_q > target_eff) begin
      duty_actual_d = (ramp_step_q >= down_gap) ? target_eff : duty_actual_q - ramp_step_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      duty_target_q <= '0;
      duty_actual_q <= '0;
      ramp_step_q   <= '0;
      enable_q      <= 1'b0;
      pwm_q         <= 1'b0;
`ifdef FAN_CONTROL_AUTO_MODE_EN
      mode_q        <= ModeManual;
      thr_low_q     <= '0;
      thr_high_q    <= '0;
      state_q       <= AutoLow;
`endif
    end else begin
      if (wr_en_i) begin
        case (reg_sel_i)
          RegDutyTarget: duty_target_q <= wdata_i[PWM_BITS-1:0];
          RegRampStep:   ramp_step_q   <= wdata_i[PWM_BITS-1:0];
          RegEnable:     enable_q      <= wdata_i[0];
`ifdef FAN_CONTROL_AUTO_MODE_EN
          RegMode:       mode_q        <= wdata_i[0];
          RegThrLow:     thr_low_q     <= wdata_i;
          RegThrHigh:    thr_high_q    <= wdata_i;
`endif
          default: ;
        endcase
      end
      if (boundary_i) duty_actual_q <= duty_actual_d;
      pwm_q <= enable_q && (duty_actual_q == DutyMax || counter_i < duty_actual_q);
`ifdef FAN_CONTROL_AUTO_MODE_EN
      state_q <= state_d;
`endif
    end
  end

  always_comb begin
    rdata_o = '0;
    case (reg_sel_i)
      RegDutyTarget: rdata_o = 32'(duty_target_q);
      RegDutyActual: rdata_o = 32'(duty_actual_q);
      RegRampStep:   rdata_o = 32'(ramp_step_q);
      RegEnable:     rdata_o = 32'(enable_q);
`ifdef FAN_CONTROL_AUTO_MODE_EN
      RegMode:       rdata_o = 32'(mode_q);
      RegThrLow:     rdata_o = thr_low_q;
      RegThrHigh:    rdata_o = thr_high_q;
      RegAutoState:  rdata_o = 32'(state_q);
`endif
      default:       rdata_o = '0;
    endcase
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/fan_control_multi.sv
// Multi-channel fan PWM controller with Avalon-MM register access, shared prescaler and counter.
// Auto (current-threshold) mode is compiled in only with FAN_CONTROL_AUTO_MODE_EN.
module fan_control_multi
  import fan_control_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned PRESCALE     = 49
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                address,
  input  logic                      write,
  input  logic                      read,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic [32*NUM_CHANNELS-1:0] current_average,
  output logic [NUM_CHANNELS-1:0]   pwm
);

  localparam int unsigned PsW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  logic [PsW-1:0]      prescale_q;
  logic [PWM_BITS-1:0] counter_q;
  logic                tick, boundary;
  logic [4:0]          ch_sel;
  logic [2:0]          reg_sel;
  logic [31:0]         ch_rdata [NUM_CHANNELS];
  logic [31:0]         rdata_mux;

  assign ch_sel   = address[7:3];
  assign reg_sel  = address[2:0];
  assign tick     = (prescale_q == PsW'(PRESCALE));
  assign boundary = tick && (counter_q == '1);

  always_ff @(posedge clock) begin
    if (reset) begin
      prescale_q <= '0;
      counter_q  <= '0;
      readdata   <= '0;
    end else begin
      prescale_q <= tick ? '0 : prescale_q + 1'b1;
      if (tick) counter_q <= counter_q + 1'b1;
      readdata <= read ? rdata_mux : '0;
    end
  end

  // Unimplemented channels fall through to zero.
  always_comb begin
    rdata_mux = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (ch_sel == 5'(i)) rdata_mux = ch_rdata[i];
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    fan_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .wr_en_i    (write && (ch_sel == 5'(i))),
      .reg_sel_i  (reg_sel),
      .wdata_i    (writedata),
      .boundary_i (boundary),
      .counter_i  (counter_q),
      .current_i  (current_average[32*i +: 32]),
      .rdata_o    (ch_rdata[i]),
      .pwm_o      (pwm[i])
    );
  end

endmodule

// File: tb/tb_fan_control_multi.sv
// Self-checking bench for fan_control_multi (PRESCALE=0, PWM_BITS=8, 4 channels); auto-mode
// checks are built when FAN_CONTROL_AUTO_MODE_EN is defined.
module tb_fan_control_multi;

  localparam int unsigned NCH = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        address = '0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [32*NCH-1:0] current_average = '0;
  logic [NCH-1:0]    pwm;

  int checks = 0;
  int errors = 0;

  // With PRESCALE=0 the shared counter advances every clock: the period is 256 clocks.
  logic [7:0]  model_cnt = '0;
  int unsigned m_tgt[NCH];
  int unsigned m_stp[NCH];
  int unsigned m_act[NCH];
  bit          m_en[NCH];

  fan_control_multi #(
    .NUM_CHANNELS(NCH),
    .PWM_BITS    (8),
    .PRESCALE    (0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .address        (address),
    .write          (write),
    .read           (read),
    .writedata      (writedata),
    .readdata       (readdata),
    .current_average(current_average),
    .pwm            (pwm)
  );

  always #5 clock = ~clock;

  always @(posedge clock) model_cnt <= reset ? 8'd0 : model_cnt + 8'd1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Bus tasks are entered and left on a falling edge.
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    address = {ch[4:0], r[2:0]};
    writedata = d;
    write = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] d);
    address = {ch[4:0], r[2:0]};
    read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic wrrd(input int ch, input int r, input logic [31:0] wd, output logic [31:0] d);
    address = {ch[4:0], r[2:0]};
    writedata = wd;
    write = 1'b1;
    read = 1'b1;
    @(negedge clock);
    write = 1'b0;
    read = 1'b0;
    d = readdata;
  endtask

  // Wait until one period boundary has passed, then stop mid-period.
  task automatic after_boundary();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (model_cnt != 8'd0 && n < 600);
    while (model_cnt != 8'd128 && n < 600) begin
      @(negedge clock);
      n++;
    end
    if (n >= 600) check("boundary_wait", 32'(n), 32'd0);
  endtask

  task automatic set_current(input int ch, input logic [31:0] v);
    current_average[32*ch +: 32] = v;
  endtask

  function automatic int unsigned ramp(input int unsigned a, input int unsigned t,
                                       input int unsigned s);
    if (s == 0) return t;
    if (a < t) return (a + s >= t) ? t : a + s;
    if (a > t) return (s >= a - t) ? t : a - s;
    return a;
  endfunction

  initial begin
    logic [31:0] d;
    int          cnt;
    int unsigned act;
    logic [7:0]  cprev;
    bit          exp_pwm;

    repeat (3) @(negedge clock);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset = 1'b0;
    for (int r = 0; r < 8; r++) begin
      rd(0, r, d);
      check("rst_reg_ch0", d, 32'd0);
    end

    // Fixed duty 64: high for 64 of any 256 consecutive clocks.
    wr(0, 6, 32'd1);
    wr(0, 0, 32'd64);
    after_boundary();
    rd(0, 1, d);
    check("duty64_actual", d, 32'd64);
    cnt = 0;
    repeat (256) begin
      @(negedge clock);
      if (pwm[0]) cnt++;
    end
    check("duty64_high_count", 32'(cnt), 32'd64);
    check("disabled_pwm_low", 32'(pwm[3:1]), 32'd0);

    // Ramp 0 -> 100 in steps of 16.
    wr(1, 5, 32'd16);
    wr(1, 0, 32'd100);
    act = 0;
    for (int k = 0; k < 9; k++) begin
      after_boundary();
      act = ramp(act, 100, 16);
      rd(1, 1, d);
      check("ramp16_actual", d, 32'(act));
    end

    // Out-of-range channel, RO write, same-cycle write+read.
    rd(9, 0, d);
    check("ch9_read", d, 32'd0);
    wr(9, 0, 32'hAA);
    wr(9, 6, 32'd1);
    rd(9, 6, d);
    check("ch9_read_after_wr", d, 32'd0);
    rd(1, 0, d);
    check("ch9_no_alias_ch1", d, 32'd100);
    rd(0, 0, d);
    check("ch9_no_alias_ch0", d, 32'd64);
    wr(0, 1, 32'd5);
    rd(0, 1, d);
    check("ro_write_ignored", d, 32'd64);
    wrrd(0, 0, 32'd77, d);
    check("wr_rd_same_cycle_old", d, 32'd64);
    rd(0, 0, d);
    check("wr_rd_new_value", d, 32'd77);

`ifdef FAN_CONTROL_AUTO_MODE_EN
    begin
      int unsigned cur_tab[6] = '{201, 150, 100, 99, 200, 201};
      int unsigned st_tab[6]  = '{1, 1, 1, 0, 0, 1};
      int unsigned dt_tab[6]  = '{255, 255, 255, 32, 32, 255};
      wr(2, 6, 32'd1);
      wr(2, 2, 32'd1);
      wr(2, 3, 32'd100);
      wr(2, 4, 32'd200);
      wr(2, 0, 32'd32);
      rd(2, 2, d);
      check("auto_mode_rb", d, 32'd1);
      rd(2, 4, d);
      check("auto_thr_high_rb", d, 32'd200);
      after_boundary();
      after_boundary();
      rd(2, 1, d);
      check("auto_low_duty", d, 32'd32);
      for (int k = 0; k < 6; k++) begin
        set_current(2, cur_tab[k]);
        after_boundary();
        after_boundary();
        rd(2, 7, d);
        check("auto_state", d, st_tab[k]);
        rd(2, 1, d);
        check("auto_duty", d, dt_tab[k]);
      end
      wr(2, 6, 32'd0);
      rd(2, 7, d);
      check("auto_disable_forces_low", d, 32'd0);
    end
`else
    wr(0, 2, 32'd1);
    wr(0, 4, 32'd5);
    wr(0, 3, 32'd1);
    set_current(0, 32'd1000);
    for (int r = 2; r < 5; r++) begin
      rd(0, r, d);
      check("manual_only_reg", d, 32'd0);
    end
    rd(0, 7, d);
    check("manual_only_state", d, 32'd0);
    after_boundary();
    after_boundary();
    rd(0, 1, d);
    check("manual_only_duty", d, 32'd77);
`endif

    // Reset mid-ramp while pwm[0] is high.
    wr(1, 5, 32'd1);
    wr(1, 0, 32'd255);
    wr(1, 6, 32'd1);
    after_boundary();
    cnt = 0;
    while (model_cnt > 8'd70 && cnt < 300) begin
      @(negedge clock);
      cnt++;
    end
    @(negedge clock);
    check("pwm_high_before_reset", 32'(pwm[0]), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("reset_pwm_low", 32'(pwm), 32'd0);
    check("reset_readdata", readdata, 32'd0);
    reset = 1'b0;
    set_current(0, 32'd0);
    set_current(2, 32'd0);
    for (int ch = 0; ch < 4; ch++) begin
      for (int r = 0; r < 8; r++) begin
        rd(ch, r, d);
        check("reset_reg_clear", d, 32'd0);
      end
    end

    // Randomized configuration against the ramp model.
    for (int ch = 0; ch < 4; ch++) begin
      m_tgt[ch] = 0;
      m_stp[ch] = 0;
      m_act[ch] = 0;
      m_en[ch]  = 1'b0;
    end
    after_boundary();
    for (int round = 0; round < 14; round++) begin
      int ch;
      ch = int'($urandom_range(0, 3));
      m_tgt[ch] = $urandom_range(0, 255);
      m_stp[ch] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 64);
      m_en[ch]  = 1'($urandom_range(0, 1));
      wr(ch, 0, m_tgt[ch]);
      wr(ch, 5, m_stp[ch]);
      wr(ch, 6, 32'(m_en[ch]));
      after_boundary();
      for (int c = 0; c < 4; c++) m_act[c] = ramp(m_act[c], m_tgt[c], m_stp[c]);
      for (int c = 0; c < 4; c++) begin
        rd(c, 1, d);
        check("rand_duty_actual", d, 32'(m_act[c]));
      end
      repeat (3) @(negedge clock);
      cprev = model_cnt - 8'd1;
      for (int c = 0; c < 4; c++) begin
        exp_pwm = m_en[c] && (m_act[c] == 255 || 32'(cprev) < m_act[c]);
        check("rand_pwm", 32'(pwm[c]), 32'(exp_pwm));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fan_control_multi.md
FAN_CONTROL_MULTI -- requirements
Module: fan_control_multi

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of fan channels (1..32).
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter and duty width.
REQ-003 SHALL have parameter PRESCALE, default 49, prescaler terminal count; one PWM count every PRESCALE+1 clocks.
REQ-004 SHALL have ports: clock  in  1  system clock; one clock, all logic on its rising edge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: address  in  8  Avalon-MM word address; [7:3] channel, [2:0] register.
REQ-007 SHALL have ports: write / read  in  1 each  Avalon-MM strobes; writedata  in  32; readdata  out  32.
REQ-008 SHALL have ports: current_average  in  32*NUM_CHANNELS  per-channel unsigned current, channel n at [32n+31:32n].
REQ-009 SHALL have ports: pwm  out  NUM_CHANNELS  per-channel fan drive.

Function
REQ-010 SHALL decode per-channel registers: 0 duty_target (RW, PWM_BITS), 1 duty_actual (RO), 2 mode (RW, bit0: 0 manual, 1 auto), 3 thr_low (RW, 32), 4 thr_high (RW, 32), 5 ramp_step (RW, PWM_BITS), 6 enable (RW, bit0), 7 auto_state (RO, bit0).
REQ-011 SHALL ignore writes to RO registers and to channels >= NUM_CHANNELS; reads of those return 0.
REQ-012 SHALL present readdata one cycle after read is sampled (fixed read latency 1); no wait states; write and read in same cycle: write takes effect, read returns pre-write value.
REQ-013 SHALL run one shared prescaler 0..PRESCALE; tick in the cycle it equals PRESCALE, then wrap to 0.
REQ-014 SHALL run one shared PWM counter advancing on tick, wrapping from 2^PWM_BITS-1 to 0; a wrap is the period boundary.
REQ-015 SHALL drive pwm[n] = enable[n] AND (duty_actual[n] == all-ones OR counter < duty_actual[n]), registered (1 cycle after counter).
REQ-016 SHALL update duty_actual only at period boundaries, toward the effective target by ramp_step, saturating at the target without overshoot; ramp_step 0 loads target directly.
REQ-017 SHALL use effective target = duty_target in manual mode; in auto mode = all-ones in state HIGH, duty_target in state LOW.
REQ-018 SHALL run per-channel auto FSM {LOW, HIGH}, evaluated at period boundaries: LOW->HIGH when current > thr_high; HIGH->LOW when current < thr_low; otherwise hold; values equal to a threshold hold state.
REQ-019 SHALL force FSM to LOW when mode is written to manual or enable is cleared.
REQ-020 SHALL, with enable[n]=0, hold pwm[n]=0 while duty_actual[n] still ramps normally.

Reset
REQ-021 SHALL, on reset, clear prescaler, counter, all registers, FSM to LOW, pwm to 0, readdata to 0.
REQ-022 SHALL abandon a ramp in progress on reset mid-period; first period after reset starts at counter 0.

Configuration
REQ-023 SHALL compile auto mode (REQ-017 auto branch, REQ-018, REQ-019, registers 3, 4, 7) only when FAN_CONTROL_AUTO_MODE_EN is defined.
REQ-024 SHALL, without FAN_CONTROL_AUTO_MODE_EN, treat every channel as manual; mode, thr_low, thr_high, auto_state read 0, writes ignored.

Structure
REQ-025 SHALL place register offsets, auto-state enum and mode encoding in package fan_control_pkg.
REQ-026 SHALL instantiate one sub-module fan_pwm_channel per channel (registers, ramp, FSM, pwm compare); prescaler, counter and bus decode stay in the top.

Verification
REQ-027 SHALL test: PRESCALE=0, PWM_BITS=8, ch0 enable=1, duty_target=64 -> pwm[0] high 64 of every 256 clocks.
REQ-028 SHALL test: ramp_step=16, duty_target 0->100 -> duty_actual 16,32,...,96,100 at successive period boundaries, then stable.
REQ-029 SHALL test: auto, thr_low=100, thr_high=200, duty_target=32; current 201 -> HIGH, duty 255; 150 -> stays HIGH; 99 -> LOW, duty 32; exactly 200 -> no transition.
REQ-030 SHALL test: read address {5'd9,3'd0} with NUM_CHANNELS=4 -> readdata 0; write ignored; write+read same cycle on duty_target returns old value.
REQ-031 SHALL test: reset asserted mid-ramp with pwm high -> next cycle pwm=0, all registers 0; without FAN_CONTROL_AUTO_MODE_EN, write mode=1 -> reads 0, channel stays manual.
